// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcode map, FSM states and the
// default operand width. Optional feature macro: ALU_SEQ_ERR_EN.
package alu_seq_pkg;

   localparam int DEF_DATA_W = 32;

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_GE  = 4'b0010;
   localparam logic [3:0] OP_LT  = 4'b0011;
   localparam logic [3:0] OP_NE  = 4'b0100;
   localparam logic [3:0] OP_EQ  = 4'b0101;
   localparam logic [3:0] OP_AND = 4'b0110;
   localparam logic [3:0] OP_OR  = 4'b0111;
   localparam logic [3:0] OP_XOR = 4'b1000;
   localparam logic [3:0] OP_ROL = 4'b1001;
   localparam logic [3:0] OP_ROR = 4'b1010;
   localparam logic [3:0] OP_SLL = 4'b1011;
   localparam logic [3:0] OP_SRL = 4'b1100;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_DRIVE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   // Opcodes above SRL have no ALU function assigned.
   function automatic logic op_is_legal(input logic [3:0] op);
      return (op <= OP_SRL);
   endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Result FIFO for the ALU sequencer. Head data reads as zero while empty so
// the response fields are clean after reset without clearing the storage.
module alu_seq_fifo
   import alu_seq_pkg::*;
#(
   parameter int WIDTH = DEF_DATA_W + 5,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [CW-1:0]    r_count;
   logic             w_push;
   logic             w_pop;

   assign w_push  = i_push && (r_count != LP_DEPTH);
   assign w_pop   = i_pop && (r_count != '0);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

   // Storage array: written on push, never reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= i_wdata;
      end
   end

   // Pointers and occupancy; a simultaneous push and pop keeps the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/alu_seq_driver.sv
// Sequencer driving an external combinational ALU: accepts one request,
// holds the operands for one settle cycle, captures the result into a FIFO.
// Optional macro ALU_SEQ_ERR_EN: illegal opcodes return data 0 with rsp_err.
module alu_seq_driver
   import alu_seq_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_op,
   input  logic [DATA_W-1:0] req_a,
   input  logic [DATA_W-1:0] req_b,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_cnt,
   input  logic [DATA_W-1:0] alu_result,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic [3:0]        rsp_op,
   output logic              rsp_err,
   output logic              busy,
   output logic [15:0]       op_count
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] LP_DEPTH = CW'(FIFO_DEPTH);

`ifdef ALU_SEQ_ERR_EN
   localparam int FW = DATA_W + 5;
`else
   localparam int FW = DATA_W + 4;
`endif

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_accept;
   logic              w_push;
   logic [DATA_W-1:0] r_alu_a;
   logic [DATA_W-1:0] r_alu_b;
   logic [3:0]        r_alu_cnt;
   logic [15:0]       r_op_count;
   logic [FW-1:0]     w_push_data;
   logic [FW-1:0]     w_head;
   logic              w_empty;
   logic [CW-1:0]     w_count;

   assign req_ready = (r_state == ST_IDLE) && (w_count < LP_DEPTH);
   assign busy      = (r_state != ST_IDLE);
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_cnt   = r_alu_cnt;
   assign op_count  = r_op_count;
   assign rsp_valid = !w_empty;
   assign rsp_data  = w_head[FW-1 -: DATA_W];

`ifdef ALU_SEQ_ERR_EN
   logic              w_illegal;
   logic [DATA_W-1:0] w_res;
   assign w_illegal   = !op_is_legal(r_alu_cnt);
   assign w_res       = w_illegal ? '0 : alu_result;
   assign w_push_data = {w_res, r_alu_cnt, w_illegal};
   assign rsp_op      = w_head[4:1];
   assign rsp_err     = w_head[0];
`else
   assign w_push_data = {alu_result, r_alu_cnt};
   assign rsp_op      = w_head[3:0];
   assign rsp_err     = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next state plus accept/push strobes; one ALU settle cycle in DRIVE.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_push      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               w_accept    = 1'b1;
               w_state_nxt = ST_DRIVE;
            end
         end
         ST_DRIVE: begin
            w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ALU drive registers: loaded on accept, held until the next accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_a   <= '0;
         r_alu_b   <= '0;
         r_alu_cnt <= '0;
      end else if (w_accept) begin
         r_alu_a   <= req_a;
         r_alu_b   <= req_b;
         r_alu_cnt <= req_op;
      end
   end

   // Completed-operation counter, wraps at 16 bits.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         r_op_count <= '0;
      else if (w_push) r_op_count <= r_op_count + 16'd1;
   end

   alu_seq_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata (w_push_data),
      .i_pop   (rsp_ready),
      .o_rdata (w_head),
      .o_empty (w_empty),
      .o_count (w_count)
   );

endmodule

// File: tb/tb_alu_seq_driver.sv
// Self-checking bench for alu_seq_driver with a queue-based reference model.
// Honours ALU_SEQ_ERR_EN to match the build of the design.
module tb_alu_seq_driver;

   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready;
   logic [3:0]    req_op;
   logic [DW-1:0] req_a;
   logic [DW-1:0] req_b;
   logic [DW-1:0] alu_a;
   logic [DW-1:0] alu_b;
   logic [3:0]    alu_cnt;
   logic [DW-1:0] alu_result;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_data;
   logic [3:0]    rsp_op;
   logic          rsp_err;
   logic          busy;
   logic [15:0]   op_count;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 1'b0;

   always #5 clk = ~clk;

   alu_seq_driver #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cnt(alu_cnt), .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_op(rsp_op), .rsp_err(rsp_err), .busy(busy), .op_count(op_count)
   );

   // External combinational ALU.
   function automatic logic [DW-1:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [3:0] op);
      logic [DW-1:0] r;
      int unsigned sh;
      sh = b % DW;
      case (op)
         4'd0:  r = a + b;
         4'd1:  r = a - b;
         4'd2:  r = (a >= b) ? 32'd1 : 32'd0;
         4'd3:  r = (a < b)  ? 32'd1 : 32'd0;
         4'd4:  r = (a != b) ? 32'd1 : 32'd0;
         4'd5:  r = (a == b) ? 32'd1 : 32'd0;
         4'd6:  r = a & b;
         4'd7:  r = a | b;
         4'd8:  r = a ^ b;
         4'd9:  r = (sh == 0) ? a : ((a << sh) | (a >> (DW - sh)));
         4'd10: r = (sh == 0) ? a : ((a >> sh) | (a << (DW - sh)));
         4'd11: r = a << sh;
         4'd12: r = a >> sh;
         default: r = a + b + 32'h0000_1000;
      endcase
      return r;
   endfunction

   assign alu_result = alu_fn(alu_a, alu_b, alu_cnt);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [DW-1:0] d;
      logic [3:0]    op;
      logic          err;
   } rsp_t;

   rsp_t          m_q[$];
   int            m_age;       // -1: nothing in flight; else edges since accept
   logic [DW-1:0] m_a, m_b;
   logic [3:0]    m_op;
   logic [15:0]   m_opcnt;
   bit            m_rdy;
   rsp_t          m_new;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         m_age   = -1;
         m_a     = '0;
         m_b     = '0;
         m_op    = '0;
         m_opcnt = '0;
      end else begin
         m_rdy = (m_age < 0) && (m_q.size() < DEPTH);
         if (rsp_ready && m_q.size() > 0) void'(m_q.pop_front());
         if (m_age == 1) begin
`ifdef ALU_SEQ_ERR_EN
            if (m_op > 4'd12) m_new = '{d: '0, op: m_op, err: 1'b1};
            else              m_new = '{d: alu_fn(m_a, m_b, m_op), op: m_op, err: 1'b0};
`else
            m_new = '{d: alu_fn(m_a, m_b, m_op), op: m_op, err: 1'b0};
`endif
            m_q.push_back(m_new);
            m_opcnt = m_opcnt + 16'd1;
            m_age   = -1;
         end else if (m_age == 0) begin
            m_age = 1;
         end else if (req_valid && m_rdy) begin
            m_a   = req_a;
            m_b   = req_b;
            m_op  = req_op;
            m_age = 0;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (cmp_en && !rst) begin
         chk("req_ready", req_ready, (m_age < 0) && (m_q.size() < DEPTH));
         chk("busy",      busy,      m_age >= 0);
         chk("alu_a",     alu_a,     m_a);
         chk("alu_b",     alu_b,     m_b);
         chk("alu_cnt",   alu_cnt,   m_op);
         chk("op_count",  op_count,  m_opcnt);
         chk("rsp_valid", rsp_valid, m_q.size() > 0);
         chk("rsp_data",  rsp_data,  (m_q.size() > 0) ? m_q[0].d   : '0);
         chk("rsp_op",    rsp_op,    (m_q.size() > 0) ? m_q[0].op  : 4'd0);
         chk("rsp_err",   rsp_err,   (m_q.size() > 0) ? m_q[0].err : 1'b0);
      end
   end

   // ---------------- stimulus ----------------
   // Called at a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
      bit ok;
      ok        = 1'b0;
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      for (int i = 0; i < 100; i++) begin
         if (req_ready) begin
            ok = 1'b1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      chk("req_accept", ok, 1'b1);
   endtask

   task automatic drain();
      rsp_ready = 1'b1;
      repeat (8) @(negedge clk);
      rsp_ready = 1'b0;
   endtask

   logic [DW-1:0] exp3 [3];

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_busy",      busy,      1'b0);
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_alu_a",     alu_a,     32'd0);
      rst = 1'b0;
      #1;
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_op_count",  op_count,  16'd0);
      cmp_en = 1'b1;
      @(negedge clk);

      // ADD 5+3 with the consumer ready.
      rsp_ready = 1'b1;
      send(4'b0000, 32'd5, 32'd3);
      repeat (2) @(negedge clk);
      chk("add_valid", rsp_valid, 1'b1);
      chk("add_data",  rsp_data,  32'd8);
      chk("add_op",    rsp_op,    4'b0000);
      chk("add_count", op_count,  16'd1);
      drain();

      // Illegal opcode 1110 with A=B=1.
      rsp_ready = 1'b0;
      send(4'b1110, 32'd1, 32'd1);
      repeat (2) @(negedge clk);
      chk("ill_valid", rsp_valid, 1'b1);
      chk("ill_op",    rsp_op,    4'b1110);
`ifdef ALU_SEQ_ERR_EN
      chk("ill_data",  rsp_data,  32'd0);
      chk("ill_err",   rsp_err,   1'b1);
`else
      chk("ill_data",  rsp_data,  32'h0000_1002);
      chk("ill_err",   rsp_err,   1'b0);
`endif
      drain();

      // Backpressure: four SUB 10-1 fill the FIFO, the fifth waits for a pop.
      for (int i = 0; i < 4; i++) send(4'b0001, 32'd10, 32'd1);
      repeat (2) @(negedge clk);
      req_valid = 1'b1; req_op = 4'b0001; req_a = 32'd10; req_b = 32'd1;
      for (int i = 0; i < 3; i++) begin
         chk("bp_ready_low", req_ready, 1'b0);
         @(negedge clk);
      end
      chk("bp_head", rsp_data, 32'd9);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("bp_ready_after_pop", req_ready, 1'b1);
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_busy", busy, 1'b1);
      repeat (2) @(negedge clk);
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("bp_order", rsp_data, 32'd9);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      chk("bp_empty", rsp_valid, 1'b0);

      // Push and pop on the same edge with three entries queued.
      send(4'b0000, 32'd1, 32'd1);
      send(4'b0000, 32'd2, 32'd2);
      send(4'b0000, 32'd3, 32'd3);
      repeat (2) @(negedge clk);
      send(4'b0000, 32'd50, 32'd50);
      @(negedge clk);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("pp_valid", rsp_valid, 1'b1);
      chk("pp_ready", req_ready, 1'b1);
      exp3[0] = 32'd4; exp3[1] = 32'd6; exp3[2] = 32'd100;
      rsp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("pp_order", rsp_data, exp3[i]);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      chk("pp_empty", rsp_valid, 1'b0);

      // Reset while an operation sits in DRIVE, with one result queued.
      send(4'b0000, 32'd7, 32'd7);
      repeat (2) @(negedge clk);
      send(4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00);
      #2 rst = 1'b1;
      #1;
      chk("rd_busy",    busy,    1'b0);
      chk("rd_alu_a",   alu_a,   32'd0);
      chk("rd_alu_b",   alu_b,   32'd0);
      chk("rd_alu_cnt", alu_cnt, 4'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rd_rsp_valid", rsp_valid, 1'b0);
      chk("rd_rsp_data",  rsp_data,  32'd0);
      chk("rd_op_count",  op_count,  16'd0);
      chk("rd_req_ready", req_ready, 1'b1);
      repeat (3) @(negedge clk);
      chk("rd_no_push", rsp_valid, 1'b0);

      // op_count wrap from 16'hFFFF.
      m_opcnt = 16'hFFFF;
      dut.r_op_count = 16'hFFFF;
      @(negedge clk);
      send(4'b1000, 32'd1, 32'd2);
      repeat (2) @(negedge clk);
      chk("wrap_count", op_count, 16'd0);
      chk("wrap_data",  rsp_data, 32'd3);
      drain();

      // Randomized traffic checked by the model every cycle.
      for (int i = 0; i < 600; i++) begin
         req_valid = ($urandom_range(0, 1) == 1);
         req_op    = 4'($urandom_range(0, 15));
         req_a     = $urandom;
         req_b     = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         rsp_ready = ($urandom_range(0, 9) < 6);
         @(negedge clk);
      end
      req_valid = 1'b0;
      repeat (4) @(negedge clk);
      drain();
      chk("final_empty", rsp_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
